// File: rtl/stream_pkg.sv
// Shared types and constants for the stream scheduler.
//   state_t      : scheduler FSM states
//   STREAM_DEPTH : generator buffer full threshold (bytes per burst)
//   byte_t       : one stream byte
//   wrap_inc     : increment an index modulo a non-power-of-2 count
package stream_pkg;

    typedef enum logic [1:0] {ARB, LOAD, DRAIN, GAP} state_t;

    localparam int STREAM_DEPTH = 15;

    typedef logic [7:0] byte_t;

    // Next round-robin position; wraps at n, not at the field width.
    function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int n);
        return (int'(v) + 1 >= n) ? 3'd0 : v + 3'd1;
    endfunction

endpackage

// File: rtl/stream_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req     : request vector, one bit per requester
//   ptr     : highest-priority index this round (0..N_REQ-1)
//   gnt_idx : first requesting index found scanning ptr, ptr+1, ... mod N_REQ
//   gnt_vld : at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       gnt_idx,
    output logic             gnt_vld
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [3:0]         sum;

    // Rotating a doubled copy puts req[ptr] at bit 0 of rot.
    assign dbl = {req, req};
    assign rot = N_REQ'(dbl >> ptr);

    // Scan from the far end so the lowest rotated position wins last.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = '0;
        sum     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + 4'(k);
                if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
                gnt_idx = sum[2:0];
            end
        end
    end

endmodule

// File: rtl/stream_sched.sv
// Round-robin scheduler sharing one byte-stream generator among N_REQ
// requesters. A granted requester's bytes are loaded (op_en=0) up to DEPTH
// per burst, then the generator is drained (op_en=1) until the tlast
// handshake. Long packets keep ownership across bursts.
//   clk, rst        : clock, asynchronous active-high reset
//   s_valid/s_data/s_last/s_ready : per-requester byte streams
//   gen_din/gen_push/gen_op_en    : generator load/drain controls
//   gen_tvalid/gen_tlast/m_tready : generator output handshake (observed)
//   grant_id, busy  : current owner, scheduler not idle
//   pkt_done        : pulse after a packet's final byte drained
//   timeout_err     : sticky drain-timeout flag
module stream_sched
    import stream_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DEPTH      = STREAM_DEPTH,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   s_valid,
    input  logic [8*N_REQ-1:0] s_data,
    input  logic [N_REQ-1:0]   s_last,
    output logic [N_REQ-1:0]   s_ready,
    output logic [7:0]         gen_din,
    output logic               gen_push,
    output logic               gen_op_en,
    input  logic               gen_tvalid,
    input  logic               gen_tlast,
    input  logic               m_tready,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic               pkt_done,
    output logic               timeout_err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(TIMEOUT);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                      state;
    logic [2:0]                  rr_ptr;
    logic [2:0]                  grant_q;
    logic [LW-1:0]               load_cnt;
    logic [DW-1:0]               drain_cnt;
    logic [GW-1:0]               gap_cnt;
    logic                        last_seen;
    logic                        dropped;
    logic                        pkt_done_q;
    logic                        timeout_q;

    logic [N_REQ-1:0][7:0]       data_v;
    logic [PW-1:0]               gsel;
    logic                        own_valid;
    logic                        own_last;
    byte_t                       own_data;
    logic                        accept;
    logic                        hs_last;
    logic [2:0]                  nxt_ptr;
    logic [2:0]                  gnt_idx;
    logic                        gnt_vld;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (s_valid),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign data_v    = s_data;
    assign gsel      = grant_q[PW-1:0];
    assign own_valid = s_valid[gsel];
    assign own_last  = s_last[gsel];
    assign own_data  = data_v[gsel];
    assign accept    = (state == LOAD) && own_valid && (load_cnt < LW'(DEPTH));
    assign hs_last   = gen_tvalid && gen_tlast && m_tready;
    assign nxt_ptr   = wrap_inc(grant_q, N_REQ);

    always_comb begin
        s_ready = '0;
        if (accept) s_ready[gsel] = 1'b1;
    end

    // Din is forced to zero outside LOAD so reset and idle present a clean bus.
    assign gen_push    = accept;
    assign gen_din     = (state == LOAD) ? own_data : 8'h00;
    assign gen_op_en   = (state == DRAIN);
    assign busy        = (state != ARB);
    assign grant_id    = grant_q;
    assign pkt_done    = pkt_done_q;
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            rr_ptr     <= '0;
            grant_q    <= '0;
            load_cnt   <= '0;
            drain_cnt  <= '0;
            gap_cnt    <= '0;
            last_seen  <= 1'b0;
            dropped    <= 1'b0;
            pkt_done_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            unique case (state)
                ARB: begin
                    if (gnt_vld) begin
                        grant_q  <= gnt_idx;
                        load_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        load_cnt <= load_cnt + 1'b1;
                        // s_last wins over the full condition on the DEPTH-th byte.
                        if (own_last) begin
                            last_seen <= 1'b1;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else if (load_cnt == LW'(DEPTH - 1)) begin
                            last_seen <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (hs_last) begin
                        pkt_done_q <= last_seen;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end else if (drain_cnt == DW'(TIMEOUT - 1)) begin
                        // Packet abandoned: release ownership after the gap.
                        timeout_q <= 1'b1;
                        last_seen <= 1'b0;
                        dropped   <= 1'b1;
                        rr_ptr    <= nxt_ptr;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        if (last_seen || dropped) begin
                            rr_ptr  <= nxt_ptr;
                            dropped <= 1'b0;
                            state   <= ARB;
                        end else begin
                            load_cnt <= '0;
                            state    <= LOAD;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: doc/stream_sched.md
Name: stream_sched

Overview:
- Round-robin scheduler that shares one byte-stream generator buffer (push/Din load port, op_en/tready drain port, AXI-Stream-like tdata/tvalid/tlast output) among N_REQ byte-stream requesters.
- Grants one requester at a time and moves its bytes into the generator in LOAD mode (op_en=0).
- Switches the generator to DRAIN mode (op_en=1), watches the final tlast handshake, then releases or re-arms the grant.
- Sits between the I2C testbench traffic sources and the shared stream generator.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DEPTH, 15, max bytes loaded per burst; must equal the generator full threshold
- GAP_CYCLES, 2, idle cycles with op_en=0 between bursts
- TIMEOUT, 1024, max DRAIN cycles before abort

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  N_REQ  requester i has a byte
- s_data  in  8*N_REQ  byte of requester i, bits [8i+7:8i]
- s_last  in  N_REQ  byte is last of requester i's packet
- s_ready  out  N_REQ  byte of requester i accepted this cycle
- gen_din  out  8  generator Din
- gen_push  out  1  generator push
- gen_op_en  out  1  generator op_en
- gen_tvalid  in  1  generator tvalid
- gen_tlast  in  1  generator tlast
- m_tready  in  1  downstream tready, also wired to generator
- grant_id  out  3  index of current owner
- busy  out  1  not in ARB
- pkt_done  out  1  one-cycle pulse when a packet's last byte has drained
- timeout_err  out  1  sticky; cleared only by rst

Behaviour:
- Reset values:
  - state=ARB, rr_ptr=0, load_cnt=0, gap_cnt=0, drain_cnt=0.
  - All outputs 0: s_ready=0, gen_push=0, gen_op_en=0, gen_din=0, grant_id=0, busy=0, pkt_done=0, timeout_err=0.
- Reset mid-operation aborts immediately; the generator shares rst, so no flush is needed.
- ARB:
  - Pick the first i with s_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Register grant_id=i, load_cnt=0, go to LOAD next cycle.
  - No request -> stay in ARB.
- LOAD (gen_op_en=0):
  - s_ready[grant_id] = s_valid[grant_id] && load_cnt<DEPTH, combinational. gen_push=s_ready[grant_id]; gen_din=s_data[grant_id] (combinational mux).
  - Each accepted byte: load_cnt+1. A requester stall (s_valid=0) leaves the FSM waiting in LOAD with no push.
  - Accepted byte with s_last=1: set last_seen=1, go to DRAIN next cycle.
  - Accepted byte making load_cnt==DEPTH without s_last: last_seen=0, go to DRAIN.
  - Load count is tracked internally; the generator's registered full flag is not used.
- DRAIN (gen_op_en=1, s_ready=0, gen_push=0):
  - drain_cnt increments each cycle.
  - Completion: gen_tvalid && gen_tlast && m_tready sampled high -> GAP. pkt_done=1 next cycle iff last_seen.
  - drain_cnt==TIMEOUT-1 without completion -> timeout_err=1, go to GAP; the packet is dropped, so on timeout clear last_seen and reset rr_ptr to grant_id+1.
- GAP (gen_op_en=0):
  - Lasts GAP_CYCLES cycles.
  - Then last_seen=1 -> rr_ptr=grant_id+1 mod N_REQ, go to ARB.
  - Then last_seen=0 -> LOAD with the same grant_id and load_cnt=0. Long packets keep ownership across bursts; no interleaving inside a packet.
- At most one s_ready bit is high in any cycle. Requests arriving mid-burst wait; a request withdrawn before grant is ignored.
- Width rules: load_cnt and drain_cnt use $clog2(DEPTH+1) and $clog2(TIMEOUT) bits respectively; rr_ptr wraps at N_REQ, never at a power of 2.

Decomposition:
- Shared package stream_pkg holds:
  - state enum {ARB, LOAD, DRAIN, GAP}
  - STREAM_DEPTH=15
  - byte_t typedef
- Sub-module rr_arbiter (N_REQ, inputs req and ptr, outputs gnt_idx and gnt_vld; combinational priority rotate) is instantiated once.
- The FSM and counters stay in stream_sched.

Test Plan:
- Single req0 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), m_tready=1 -> three gen_push pulses with matching gen_din, then gen_op_en=1, output bytes A1,A2,A3 with tlast on A3, pkt_done one pulse, then ARB after 2 gap cycles.
- req0 and req2 both valid at reset release, 2-byte packets each -> grant_id 0 then 2, no byte interleaving, rr_ptr=3 after the second packet.
- req1 sends 20-byte packet -> burst of 15 bytes, drain with no pkt_done, gap, burst of 5, drain, pkt_done once. req3 asserting meanwhile is not served until the end.
- m_tready held 0 in DRAIN for 1024 cycles -> timeout_err=1 sticky, gen_op_en drops, next requester granted.
- rst asserted mid-LOAD after 4 bytes -> all outputs 0 in the same cycle; new 1-byte packet after release drains correctly.
- req2 stalls s_valid for 10 cycles mid-packet -> no gen_push during the stall, grant held, completes normally.
